// File: rtl/uart_fifo_bridge_ctrl.sv
// uart_fifo_bridge_ctrl
// Moves bytes from the UART RX FIFO read port to the UART TX FIFO write port,
// adding ADD_VAL (mod 2^DATA_W) to each byte. A local message requester shares
// the TX write port under round-robin arbitration. One transaction is in flight
// at a time; each is followed by RD_GAP idle cycles so the FIFO flags settle.
//
// Ports:
//   clk_in, rst              clock, synchronous active-high reset
//   en                       enable for new grants
//   rx_empty/rx_rd_en/rx_dout  RX FIFO read port (data valid cycle after strobe)
//   tx_full/tx_wr_en/tx_din    TX FIFO write port
//   msg_req/msg_data/msg_ack   local message requester (ack = byte written)
//   busy                     controller not idle
//   rx_cnt/tx_cnt/stall_cnt  statistics (wrap, wrap, saturate)
module uart_fifo_bridge_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADD_VAL = 1,
  parameter int unsigned RD_GAP  = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  input  logic              rx_empty,
  output logic              rx_rd_en,
  input  logic [DATA_W-1:0] rx_dout,
  input  logic              tx_full,
  output logic              tx_wr_en,
  output logic [DATA_W-1:0] tx_din,
  input  logic              msg_req,
  input  logic [DATA_W-1:0] msg_data,
  output logic              msg_ack,
  output logic              busy,
  output logic [CNT_W-1:0]  rx_cnt,
  output logic [CNT_W-1:0]  tx_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned       GapW    = (RD_GAP > 1) ? $clog2(RD_GAP) : 1;
  localparam logic [GapW-1:0]   GapLast = GapW'(RD_GAP - 1);
  localparam logic [DATA_W-1:0] AddVal  = DATA_W'(ADD_VAL);
  localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);

  typedef enum logic [2:0] {StIdle, StRd, StCap, StWr, StGap} state_e;
  typedef enum logic {SrcRx, SrcMsg} src_e;

  state_e            state_q, state_d;
  src_e              prio_q, prio_d;
  src_e              src_q, src_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic rx_av, ms_av, grant_rx, grant_ms;

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    src_d       = src_q;
    hold_d      = hold_q;
    gap_d       = gap_q;
    rx_cnt_d    = rx_cnt_q;
    tx_cnt_d    = tx_cnt_q;
    stall_cnt_d = stall_cnt_q;
    rx_rd_en    = 1'b0;
    tx_wr_en    = 1'b0;
    tx_din      = '0;
    msg_ack     = 1'b0;

    rx_av    = en & ~rx_empty;
    ms_av    = en & msg_req;
    // RX wins when alone or when it holds priority; the loser gets priority next.
    grant_rx = rx_av & (~ms_av | (prio_q == SrcRx));
    grant_ms = ms_av & ~grant_rx;

    unique case (state_q)
      StIdle: begin
        if (grant_rx) begin
          state_d = StRd;
          prio_d  = SrcMsg;
        end else if (grant_ms) begin
          state_d = StWr;
          hold_d  = msg_data;
          src_d   = SrcMsg;
          prio_d  = SrcRx;
        end
      end
      StRd: begin
        rx_rd_en = 1'b1;
        rx_cnt_d = rx_cnt_q + CntOne;
        state_d  = StCap;
      end
      StCap: begin
        hold_d  = rx_dout + AddVal;
        src_d   = SrcRx;
        state_d = StWr;
      end
      StWr: begin
        tx_din = hold_q;
        if (tx_full) begin
          if (!(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CntOne;
        end else begin
          tx_wr_en = 1'b1;
          msg_ack  = (src_q == SrcMsg);
          tx_cnt_d = tx_cnt_q + CntOne;
          gap_d    = GapLast;
          state_d  = StGap;
        end
      end
      StGap: begin
        if (gap_q == '0) state_d = StIdle;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Reset aborts the transaction in its own cycle: no strobe may escape.
    if (rst) begin
      rx_rd_en = 1'b0;
      tx_wr_en = 1'b0;
      tx_din   = '0;
      msg_ack  = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= StIdle;
      prio_q      <= SrcRx;
      src_q       <= SrcRx;
      hold_q      <= '0;
      gap_q       <= '0;
      rx_cnt_q    <= '0;
      tx_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      src_q       <= src_d;
      hold_q      <= hold_d;
      gap_q       <= gap_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign rx_cnt    = rx_cnt_q;
  assign tx_cnt    = tx_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule
